hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Next-generation hazard unit for the 5-stage pipeline. Combines operand-forwarding selection with
//  load-use stall generation, multi-cycle data-memory freeze and flush abort. Sits beside ID/EX.
//  Forward selects are computed in ID and registered at the ID->EX edge, so they are stable
//  throughout EX. Generalised over operand count and load-use latency.
// PARAMETERS
//  ADDR_W    5   register-address width
//  NUM_SRC   2   source operands per instruction (3 for fused/FMA-style formats)
//  LOAD_LAT  1   bubbles required between a load in EX and its consumer in ID (1..3)
//  CNT_W     16  perf-counter width (used only with HAZARD_PERF_EN)
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               synchronous reset, active-high
//  id_rs        in   NUM_SRC*ADDR_W  ID source addresses; operand i at [i*ADDR_W +: ADDR_W]
//  id_rs_used   in   NUM_SRC         operand i is actually read by the ID instruction
//  ex_rd        in   ADDR_W          EX-stage destination
//  ex_reg_write in   1               EX instruction writes rd
//  ex_mem_read  in   1               EX instruction is a load
//  mem_rd       in   ADDR_W          MEM-stage destination
//  mem_reg_write in  1               MEM instruction writes rd
//  flush        in   1               branch/jump taken in EX; kills IF and ID
//  dmem_busy    in   1               data memory not ready; whole pipeline must hold
//  fwd_sel      out  NUM_SRC*2       registered select for operand i, 2 bits each
//  stall        out  1               hold PC and IF/ID
//  bubble       out  1               load NOP into ID/EX
//  freeze       out  1               hold every pipeline register (=dmem_busy)
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, fwd_sel=0, stall=0, bubble=0; freeze follows dmem_busy.
//  Per-operand hit (rs!=0, used):
//   hitEX = ex_reg_write & ex_rd==rs;  hitMEM = mem_reg_write & mem_rd==rs.
//   Next select: hitEX & !ex_mem_read -> 01 (MEM-stage ALU result);
//   else hitMEM -> 10 (WB result); else 00 (register file). EX takes priority over MEM.
//   Write-before-read in the regfile covers WB->ID; the unit performs no third-level forwarding.
//  load_use = ex_mem_read & any operand hitEX.
//  FSM:
//   IDLE: load_use & !flush -> LOAD_STALL, cnt=LOAD_LAT-1; stall=bubble=1 combinationally in that
//    same cycle.
//   LOAD_STALL: stall=bubble=1 while cnt>0. cnt==0 -> IDLE, and hazards re-evaluate against the new
//    EX/MEM contents. A persisting load_use re-enters LOAD_STALL.
//   flush in any state -> IDLE next cycle; stall=bubble=0 in the flush cycle; fwd_sel <= 0.
//  fwd_sel update: on a clock edge with !freeze & !stall, load the next select. With bubble=1,
//   load 0. With freeze=1, hold.
//  freeze=1: FSM state, cnt and fwd_sel all hold. stall/bubble are forced 0 (freeze dominates).
//   Exit resumes the exact prior state.
//  Latency: select is computed in ID and visible one cycle later in EX. Load-use stall costs exactly
//   LOAD_LAT cycles absent freeze.
//  Reset mid-stall: the next cycle is IDLE with all outputs 0. No pending stall survives.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds ports load_stall_cnt and freeze_cnt (out, CNT_W each).
//   They increment on each cycle with bubble=1 or freeze=1 respectively.
//   They saturate at all-ones and clear on rst.
//  Undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package hazard_pkg: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; state encoding
//   ST_IDLE/ST_LOAD_STALL; ZERO_ADDR.
//  Sub-module fwd_compare: per-operand hit/priority logic, generated NUM_SRC times.
//  FSM, counter and fwd_sel registers stay in the top level.
// TESTING
//  1 ex_rd=5 ALU write, id_rs[0]=5 -> next cycle fwd_sel[1:0]=01, no stall.
//  2 ex_rd=5 and mem_rd=5 both writing, rs[1]=5 -> fwd_sel[3:2]=01 (EX priority).
//    rd=0 writes -> 00.
//  3 LOAD_LAT=2, load ex_rd=7, rs[0]=7 used -> stall=bubble=1 for 2 cycles.
//    Then fwd_sel[1:0]=10, with id_rs_used[0]=0 -> no stall.
//  4 Load-use stall cycle 1 with dmem_busy high 3 cycles -> freeze=1, stall=0, fwd_sel held.
//    Remaining stall completes after dmem_busy drops.
//  5 flush during LOAD_STALL -> IDLE next cycle, fwd_sel=0. rst mid-stall -> all outputs 0.
//  6 HAZARD_PERF_EN, CNT_W=4, 20 bubble cycles -> load_stall_cnt=15 (saturated).

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding unit: forward-select codes,
// FSM state encoding and the hardwired-zero register address.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result sitting in EX/MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // result sitting in MEM/WB

  localparam int ZERO_ADDR = 0;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_LOAD_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_compare.sv
// Per-operand hit detection and forward-source priority (EX over MEM).
// A load hitting in EX cannot forward; it is reported via o_hit_ex so the
// top level can raise the load-use stall.
module fwd_compare
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_rs,
  input  logic              i_rs_used,
  input  logic [ADDR_W-1:0] i_ex_rd,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_read,
  input  logic [ADDR_W-1:0] i_mem_rd,
  input  logic              i_mem_reg_write,
  output logic              o_hit_ex,
  output logic [1:0]        o_sel
);

  logic w_live;
  logic w_hit_mem;

  assign w_live    = i_rs_used && (i_rs != ADDR_W'(ZERO_ADDR));
  assign o_hit_ex  = w_live && i_ex_reg_write && (i_ex_rd == i_rs);
  assign w_hit_mem = w_live && i_mem_reg_write && (i_mem_rd == i_rs);

  // Pick the youngest producer; a load in EX has no data yet, so fall to MEM.
  always_comb begin
    o_sel = FWD_RF;
    if (o_hit_ex && !i_ex_mem_read) begin
      o_sel = FWD_MEM;
    end else if (w_hit_mem) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit beside ID/EX: registered operand forward selects, load-use
// stall/bubble generation, data-memory freeze and flush abort.
// Optional feature macro: HAZARD_PERF_EN adds saturating counters of
// bubble cycles (load_stall_cnt) and freeze cycles (freeze_cnt).
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      flush,
  input  logic                      dmem_busy,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic                      freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]          load_stall_cnt,
  output logic [CNT_W-1:0]          freeze_cnt
`endif
);

  state_t                 r_state;
  logic [1:0]             r_cnt;
  logic [NUM_SRC*2-1:0]   r_fwd_sel;
  logic [NUM_SRC-1:0]     w_hit_ex;
  logic [NUM_SRC*2-1:0]   w_next_sel;
  logic                   w_load_use;
  logic                   w_stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cmp
    fwd_compare #(.ADDR_W(ADDR_W)) u_cmp (
      .i_rs            (id_rs[g*ADDR_W +: ADDR_W]),
      .i_rs_used       (id_rs_used[g]),
      .i_ex_rd         (ex_rd),
      .i_ex_reg_write  (ex_reg_write),
      .i_ex_mem_read   (ex_mem_read),
      .i_mem_rd        (mem_rd),
      .i_mem_reg_write (mem_reg_write),
      .o_hit_ex        (w_hit_ex[g]),
      .o_sel           (w_next_sel[g*2 +: 2])
    );
  end

  assign w_load_use = ex_mem_read && (|w_hit_ex);

  // Stall is combinational so the first bubble lands in the detection cycle;
  // freeze, flush and reset all suppress it.
  always_comb begin
    w_stall = 1'b0;
    if (!rst && !dmem_busy && !flush) begin
      if (r_state == ST_LOAD_STALL && r_cnt != 2'd0) begin
        w_stall = 1'b1;
      end else begin
        w_stall = w_load_use;
      end
    end
  end

  assign stall   = w_stall;
  assign bubble  = w_stall;
  assign freeze  = dmem_busy;
  assign fwd_sel = r_fwd_sel;

  // FSM, remaining-bubble counter and forward selects; everything holds on freeze.
  // LOAD_STALL with cnt==0 behaves like IDLE so a persisting hazard re-stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_fwd_sel <= '0;
    end else if (!dmem_busy) begin
      if (flush) begin
        r_state   <= ST_IDLE;
        r_cnt     <= 2'd0;
        r_fwd_sel <= '0;
      end else if (r_state == ST_LOAD_STALL && r_cnt != 2'd0) begin
        r_cnt     <= r_cnt - 2'd1;
        r_fwd_sel <= '0;
      end else if (w_load_use) begin
        r_state   <= ST_LOAD_STALL;
        r_cnt     <= 2'(LOAD_LAT - 1);
        r_fwd_sel <= '0;
      end else begin
        r_state   <= ST_IDLE;
        r_cnt     <= 2'd0;
        r_fwd_sel <= w_next_sel;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_load_stall_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;

  // Saturating event counters for bubble and freeze cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_stall_cnt <= '0;
      r_freeze_cnt     <= '0;
    end else begin
      if (w_stall && (r_load_stall_cnt != '1)) begin
        r_load_stall_cnt <= r_load_stall_cnt + 1'b1;
      end
      if (dmem_busy && (r_freeze_cnt != '1)) begin
        r_freeze_cnt <= r_freeze_cnt + 1'b1;
      end
    end
  end

  assign load_stall_cnt = r_load_stall_cnt;
  assign freeze_cnt     = r_freeze_cnt;
`endif

endmodule
